// File: rtl/display_pkg.sv
// 480p raster constants and helpers shared by the timing generator and the paint stages.
package display_pkg;

  localparam int unsigned H_RES  = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned V_RES  = 480;
  localparam int unsigned V_FP   = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 33;

  localparam bit H_POL = 1'b0;
  localparam bit V_POL = 1'b0;

  localparam int unsigned CORDW  = 10;
  localparam int unsigned FRAMEW = 16;

  localparam int unsigned H_TOTAL      = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_RES + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_RES + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_RES + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Half-open window test: lo <= pos < hi.
  function automatic bit in_window(input int unsigned pos,
                                   input int unsigned lo,
                                   input int unsigned hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/display_axis_counter.sv
// One raster axis: position counter with registered sync; active and wrap are
// combinational views used by the parent to build its registered strobes.
module display_axis_counter
  import display_pkg::*;
#(
  parameter int unsigned RES  = 640,
  parameter int unsigned FP   = 16,
  parameter int unsigned SYNC = 96,
  parameter int unsigned BP   = 48,
  parameter bit          POL  = 1'b0,
  parameter int unsigned W    = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] pos,
  output logic         sync,
  output logic         active,
  output logic         wrap
);

  localparam int unsigned TOTAL      = RES + FP + SYNC + BP;
  localparam int unsigned SYNC_START = RES + FP;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;

  logic [W-1:0] pos_q, pos_d;
  logic         sync_q, sync_d;

  // active describes the position about to be loaded, so the parent's de stays aligned.
  always_comb begin
    wrap   = (pos_q == W'(TOTAL - 1));
    pos_d  = pos_q;
    if (step) begin
      pos_d = wrap ? '0 : pos_q + W'(1);
    end
    active = (32'(pos_d) < RES);
    sync_d = in_window(32'(pos_d), SYNC_START, SYNC_END) ? POL : ~POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= W'(TOTAL - 1);
      sync_q <= ~POL;
    end else begin
      pos_q  <= pos_d;
      sync_q <= sync_d;
    end
  end

  assign pos  = pos_q;
  assign sync = sync_q;

endmodule

// File: rtl/display_timing_480p.sv
// Raster timing generator: coordinates, syncs, data enable, line/frame strobes
// and a frame counter, all registered and advanced by a pixel clock enable.
module display_timing_480p #(
  parameter int unsigned CORDW  = display_pkg::CORDW,
  parameter int unsigned H_RES  = display_pkg::H_RES,
  parameter int unsigned H_FP   = display_pkg::H_FP,
  parameter int unsigned H_SYNC = display_pkg::H_SYNC,
  parameter int unsigned H_BP   = display_pkg::H_BP,
  parameter int unsigned V_RES  = display_pkg::V_RES,
  parameter int unsigned V_FP   = display_pkg::V_FP,
  parameter int unsigned V_SYNC = display_pkg::V_SYNC,
  parameter int unsigned V_BP   = display_pkg::V_BP,
  parameter bit          H_POL  = display_pkg::H_POL,
  parameter bit          V_POL  = display_pkg::V_POL,
  parameter int unsigned FRAMEW = display_pkg::FRAMEW
) (
  input  logic              clk_pix,
  input  logic              rst_pix_n,
  input  logic              ce,
  output logic [CORDW-1:0]  sx,
  output logic [CORDW-1:0]  sy,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              line,
  output logic              frame,
  output logic [FRAMEW-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  if ((((H_TOTAL - 1) >> CORDW) != 0) || (((V_TOTAL - 1) >> CORDW) != 0)) begin : g_cordw_check
    $error("display_timing_480p: CORDW too narrow for the raster totals");
  end

  logic h_active, h_wrap;
  logic v_active, v_wrap;
  logic v_step;

  assign v_step = h_wrap & ce;

  display_axis_counter #(
    .RES (H_RES),
    .FP  (H_FP),
    .SYNC(H_SYNC),
    .BP  (H_BP),
    .POL (H_POL),
    .W   (CORDW)
  ) u_h_axis (
    .clk   (clk_pix),
    .rst_n (rst_pix_n),
    .step  (ce),
    .pos   (sx),
    .sync  (hsync),
    .active(h_active),
    .wrap  (h_wrap)
  );

  display_axis_counter #(
    .RES (V_RES),
    .FP  (V_FP),
    .SYNC(V_SYNC),
    .BP  (V_BP),
    .POL (V_POL),
    .W   (CORDW)
  ) u_v_axis (
    .clk   (clk_pix),
    .rst_n (rst_pix_n),
    .step  (v_step),
    .pos   (sy),
    .sync  (vsync),
    .active(v_active),
    .wrap  (v_wrap)
  );

  logic              de_q, de_d;
  logic              line_q, line_d;
  logic              frame_q, frame_d;
  logic [FRAMEW-1:0] frame_cnt_q, frame_cnt_d;

  // Strobes are derived from the wrap of the position being left, so they land with (0,y).
  always_comb begin
    line_d      = ce & h_wrap;
    frame_d     = ce & h_wrap & v_wrap;
    de_d        = h_active & v_active;
    frame_cnt_d = frame_cnt_q;
    if (frame_d) begin
      frame_cnt_d = frame_cnt_q + FRAMEW'(1);
    end
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      de_q        <= 1'b0;
      line_q      <= 1'b0;
      frame_q     <= 1'b0;
      frame_cnt_q <= '1;
    end else begin
      de_q        <= de_d;
      line_q      <= line_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign de        = de_q;
  assign line      = line_q;
  assign frame     = frame_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_display_timing_480p.sv
// Directed bench: default 640x480 instance for reset/line/async-reset timing, and a
// tiny 16x8 raster with positive syncs and 2-bit frame counter for whole-frame behaviour.
module tb_display_timing_480p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst_n, ce;
  logic [9:0]  sx, sy;
  logic        hsync, vsync, de, line, frame;
  logic [15:0] frame_cnt;

  display_timing_480p u_dut (
    .clk_pix  (clk),
    .rst_pix_n(rst_n),
    .ce       (ce),
    .sx       (sx),
    .sy       (sy),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .line     (line),
    .frame    (frame),
    .frame_cnt(frame_cnt)
  );

  // Small raster: H 8+2+3+3=16, V 4+1+2+1=8, positive syncs
  logic        rst_s_n, ce_s;
  logic [3:0]  sx_s, sy_s;
  logic        hsync_s, vsync_s, de_s, line_s, frame_s;
  logic [1:0]  frame_cnt_s;

  display_timing_480p #(
    .CORDW(4), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_RES(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .FRAMEW(2)
  ) u_small (
    .clk_pix  (clk),
    .rst_pix_n(rst_s_n),
    .ce       (ce_s),
    .sx       (sx_s),
    .sy       (sy_s),
    .hsync    (hsync_s),
    .vsync    (vsync_s),
    .de       (de_s),
    .line     (line_s),
    .frame    (frame_s),
    .frame_cnt(frame_cnt_s)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic check_first_pixel(input string pfx);
    check({pfx, "_sx"},    32'(sx), 0);
    check({pfx, "_sy"},    32'(sy), 0);
    check({pfx, "_de"},    32'(de), 1);
    check({pfx, "_line"},  32'(line), 1);
    check({pfx, "_frame"}, 32'(frame), 1);
    check({pfx, "_cnt"},   32'(frame_cnt), 0);
    check({pfx, "_hs"},    32'(hsync), 1);
    check({pfx, "_vs"},    32'(vsync), 1);
  endtask

  int idx, cnt_e, strobes, last_k, de_cnt, sxe, sye;
  bit applied, exp_line, exp_frame;

  initial begin
    rst_n = 1'b0; ce = 1'b0; rst_s_n = 1'b0; ce_s = 1'b0;
    run(3);

    check("rst_sx",    32'(sx), 799);
    check("rst_sy",    32'(sy), 524);
    check("rst_de",    32'(de), 0);
    check("rst_hs",    32'(hsync), 1);
    check("rst_vs",    32'(vsync), 1);
    check("rst_line",  32'(line), 0);
    check("rst_frame", 32'(frame), 0);
    check("rst_cnt",   32'(frame_cnt), 32'hffff);

    rst_n = 1'b1; ce = 1'b1;
    tick();
    check_first_pixel("first");
    tick();
    check("px1_sx", 32'(sx), 1);
    check("px1_line", 32'(line), 0);
    check("px1_frame", 32'(frame), 0);

    run(638);
    check("sx639", 32'(sx), 639);
    check("de639", 32'(de), 1);
    tick();
    check("de640", 32'(de), 0);
    run(15);
    check("hs655", 32'(hsync), 1);
    tick();
    check("sx656", 32'(sx), 656);
    check("hs656", 32'(hsync), 0);
    run(95);
    check("hs751", 32'(hsync), 0);
    tick();
    check("hs752", 32'(hsync), 1);
    run(47);
    check("sx799", 32'(sx), 799);
    check("sy799", 32'(sy), 0);
    check("line799", 32'(line), 0);
    tick();
    check("wrap_sx", 32'(sx), 0);
    check("wrap_sy", 32'(sy), 1);
    check("wrap_line", 32'(line), 1);
    check("wrap_frame", 32'(frame), 0);
    check("wrap_de", 32'(de), 1);

    // ce low: everything holds, strobe drops
    ce = 1'b0;
    tick();
    check("hold_sx", 32'(sx), 0);
    check("hold_sy", 32'(sy), 1);
    check("hold_line", 32'(line), 0);
    tick();
    check("hold2_sx", 32'(sx), 0);
    check("hold2_de", 32'(de), 1);
    ce = 1'b1;
    tick();
    check("resume_sx", 32'(sx), 1);
    check("resume_line", 32'(line), 0);

    run(299);
    check("pre_rst_sx", 32'(sx), 300);
    check("pre_rst_sy", 32'(sy), 1);
    check("pre_rst_cnt", 32'(frame_cnt), 0);

    // Async reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("arst_sx", 32'(sx), 799);
    check("arst_sy", 32'(sy), 524);
    check("arst_hs", 32'(hsync), 1);
    check("arst_de", 32'(de), 0);
    check("arst_cnt", 32'(frame_cnt), 32'hffff);
    tick();
    check("arst_hold_sx", 32'(sx), 799);
    rst_n = 1'b1;
    tick();
    check_first_pixel("rerst");
    tick();
    check("rerst_px1_sx", 32'(sx), 1);
    ce = 1'b0;

    // Small raster, ce every third clock
    check("s_rst_sx", 32'(sx_s), 15);
    check("s_rst_sy", 32'(sy_s), 7);
    check("s_rst_hs", 32'(hsync_s), 0);
    check("s_rst_vs", 32'(vsync_s), 0);
    check("s_rst_cnt", 32'(frame_cnt_s), 3);

    idx = 127; cnt_e = 3; strobes = 0; last_k = 0; de_cnt = 0;
    rst_s_n = 1'b1;
    for (int k = 0; k <= 1540; k++) begin
      applied = (k % 3 == 0);
      ce_s = applied;
      tick();
      exp_line = 1'b0;
      exp_frame = 1'b0;
      if (applied) begin
        idx = (idx + 1) % 128;
        exp_line = (idx % 16 == 0);
        exp_frame = (idx == 0);
        if (exp_frame) cnt_e = (cnt_e + 1) % 4;
      end
      sxe = idx % 16;
      sye = idx / 16;
      check("s_sx",    32'(sx_s), 32'(sxe));
      check("s_sy",    32'(sy_s), 32'(sye));
      check("s_hs",    32'(hsync_s), 32'(sxe >= 10 && sxe < 13));
      check("s_vs",    32'(vsync_s), 32'(sye >= 5 && sye < 7));
      check("s_de",    32'(de_s), 32'(sxe < 8 && sye < 4));
      check("s_line",  32'(line_s), 32'(exp_line));
      check("s_frame", 32'(frame_s), 32'(exp_frame));
      check("s_cnt",   32'(frame_cnt_s), 32'(cnt_e));
      if (exp_frame) begin
        strobes++;
        if (strobes >= 2) begin
          check("s_frame_clocks", 32'(k - last_k), 384);
          check("s_de_pixels", 32'(de_cnt), 32);
        end
        if (strobes == 5) check("s_cnt_wrap", 32'(frame_cnt_s), 0);
        last_k = k;
        de_cnt = 0;
      end
      if (applied && de_s) de_cnt++;
    end
    check("s_strobes", 32'(strobes), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_timing_480p.md
# display_timing_480p

Display timing generator that drives the pixel pipeline. It produces screen coordinates, sync pulses, data enable, and line/frame strobes for a parameterised raster, 640x480 at 60 Hz by default. It sits directly upstream of the paint/colour stages and is a drop-in replacement for the simple timing block. It adds a clock enable, configurable sync polarity, single-cycle strobes and a frame counter.

## Interface
- `CORDW`, 10: coordinate width; must hold H_TOTAL-1 and V_TOTAL-1.
- `H_RES`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch.
- `H_SYNC`, 96: horizontal sync width.
- `H_BP`, 48: horizontal back porch.
- `V_RES`, 480: active lines.
- `V_FP`, 10: vertical front porch.
- `V_SYNC`, 2: vertical sync width.
- `V_BP`, 33: vertical back porch.
- `H_POL`, 0: hsync level while active (0 = negative).
- `V_POL`, 0: vsync level while active.
- `FRAMEW`, 16: frame counter width.
- `clk_pix` input 1: pixel clock.
- `rst_pix_n` input 1: reset, asynchronous, active-low.
- `ce` input 1: pixel advance enable.
- `sx` output CORDW: horizontal position; 0..H_RES-1 is the active region.
- `sy` output CORDW: vertical position; 0..V_RES-1 is the active region.
- `hsync` output 1: horizontal sync, polarity set by H_POL.
- `vsync` output 1: vertical sync, polarity set by V_POL.
- `de` output 1: data enable; high iff sx<H_RES and sy<V_RES.
- `line` output 1: one-cycle strobe when sx becomes 0.
- `frame` output 1: one-cycle strobe when (sx,sy) becomes (0,0).
- `frame_cnt` output FRAMEW: index of the current frame.

## Operation
- Derived values: H_TOTAL=H_RES+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Horizontal order: active, front porch, sync, back porch. Vertical order is the same.
- Elaboration `$error` if CORDW cannot represent H_TOTAL-1 or V_TOTAL-1.
- On each `ce`=1 cycle, sx advances by 1.
  - At sx=H_TOTAL-1, sx wraps to 0 and sy advances by 1.
  - At sy=V_TOTAL-1 together with the horizontal wrap, sy wraps to 0.
- hsync is active iff H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC (656..751 by default).
- vsync is active iff V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC (490..491 by default).
  - vsync changes only together with sy, i.e. when sx becomes 0.
- Active sync drives H_POL/V_POL; inactive sync drives the inverse.
- `frame_cnt` increments modulo 2^FRAMEW on the same cycle that `frame` asserts.
- `ce`=0 behaviour:
  - All counters, sx, sy, hsync, vsync, de and frame_cnt hold.
  - line and frame are 0, so a strobe lasts exactly one clk_pix cycle per ce.
- Reset values:
  - sx=H_TOTAL-1, sy=V_TOTAL-1.
  - de=0, hsync=!H_POL, vsync=!V_POL.
  - line=0, frame=0, frame_cnt all ones.
  - Consequence: the first ce after reset presents (0,0) with de=1, line=1, frame=1, frame_cnt=0.
- Reset mid-frame:
  - Outputs take reset values immediately on the async assertion.
  - After release, the block behaves exactly as after power-on reset; no partial frame is resumed.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- sx, sy, hsync, vsync, de, line and frame update on the same clk_pix edge and always describe the same pixel.
  - Downstream stages register off these without realignment.
- Latency from a `ce` sample to the updated outputs: 1 clk_pix cycle.
- Full frame: H_TOTAL*V_TOTAL ce pulses; de is high for H_RES*V_RES of them (307200).
- Simultaneous horizontal and vertical wrap in one cycle: line=1 and frame=1 both assert.
- ce held high continuously: 1 pixel per clock, 420000 clocks per frame.

## Structure
- Shared package `display_pkg`:
  - 480p timing localparams (H_RES, H_FP, H_SYNC, H_BP, V_*, polarities).
  - Derived totals and sync start/end constants.
  - Shared with the paint stages.
- Sub-module `display_axis_counter`, instantiated once for horizontal and once for vertical.
  - Parameters: RES, FP, SYNC, BP, POL, W.
  - Ports: clk, rst_n, step, pos, sync, active, wrap.
  - Vertical step = horizontal wrap & ce.
  - Each instance computes next-state values, and the registered outputs are taken from those next values.

## Test plan
- Reset release, ce=1:
  - Cycle 0 outputs show sx=799, sy=524, de=0, hsync=vsync=1.
  - Next cycle shows sx=0, sy=0, de=1, line=1, frame=1, frame_cnt=0.
- Line timing:
  - de falls when sx goes 639→640.
  - hsync falls at sx=656 and rises at sx=752.
  - At sx 799→0: sy increments and line=1 for exactly 1 cycle.
- Frame timing:
  - vsync low for sy=490..491 only.
  - At (799,524)→(0,0): frame=1 and frame_cnt 0→1.
  - De-high count per frame = 307200.
- ce=1 every 3rd cycle:
  - Outputs hold between pulses; line/frame pulse exactly 1 cycle.
  - Frame spans 1260000 clocks.
- Async reset asserted at (300,200) between clock edges:
  - Outputs immediately take reset values.
  - After release, the sequence matches the first scenario.
- Override H_POL=1, V_POL=1, FRAMEW=2:
  - Syncs are high only in the sync windows.
  - frame_cnt wraps 3→0 on the 5th frame strobe.
